// File: rtl/rom_reader_pkg.sv
// Shared types and width helpers for the ROM read sequencer.
package rom_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        FIN
    } state_t;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CNT_W  = DEF_ADDR_W + 1;

    // Count must represent 0..2^addr_w inclusive, hence one extra bit.
    function automatic int unsigned cnt_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/rom_ctrl.sv
// Synchronous ROM responder with a fixed, address-derived content pattern and
// configurable read latency.
module rom_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] pipe [RD_LAT];

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(a * ADDR_W'(37) + ADDR_W'(11)) ^ DATA_W'(a >> 3);
    endfunction

    // Stage 0 holds the last word read; later stages only add latency.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            pipe[0] <= rom_word(i_addr);
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign o_data = pipe[RD_LAT-1];

endmodule

// File: rtl/rom_reader.sv
// Sweeps an address range over a synchronous ROM port, one read at a time,
// streaming each word out on valid/ready and accumulating a modular checksum.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [ADDR_W-1:0]         i_base,
    input  logic [cnt_width(ADDR_W)-1:0] i_count,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_rom_en,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic [DATA_W-1:0]         i_rom_data,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_valid,
    output logic                      o_last,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_sum
);

    localparam int unsigned CNT_W = cnt_width(ADDR_W);
    localparam int unsigned LAT_W = 2;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [LAT_W-1:0]  lat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            lat        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rom_en   <= 1'b0;
            o_rom_addr <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_sum      <= '0;
        end else begin
            o_rom_en <= 1'b0;
            o_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_sum <= '0;
                        if (i_count != '0) begin
                            addr       <= i_base;
                            remaining  <= i_count;
                            o_rom_en   <= 1'b1;
                            o_rom_addr <= i_base;
                            o_busy     <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            o_done <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end

                // Read request is on the port this cycle; arm the latency count.
                ISSUE: begin
                    lat   <= LAT_W'(RD_LAT - 1);
                    state <= WAIT;
                end

                WAIT: begin
                    if (lat == '0) begin
                        o_data  <= i_rom_data;
                        o_valid <= 1'b1;
                        o_last  <= (remaining == CNT_W'(1));
                        state   <= HOLD;
                    end else begin
                        lat <= lat - LAT_W'(1);
                    end
                end

                // Beat is held until accepted; next read issues only after transfer.
                HOLD: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        o_last    <= 1'b0;
                        o_sum     <= o_sum + o_data;
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining != CNT_W'(1)) begin
                            o_rom_en   <= 1'b1;
                            o_rom_addr <= addr + ADDR_W'(1);
                            state      <= ISSUE;
                        end else begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// Randomized scoreboard bench for rom_reader driving a rom_ctrl responder.
module tb_rom_reader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RD_LAT = 1;

    logic              i_clk   = 1'b0;
    logic              i_rst   = 1'b1;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base  = '0;
    logic [ADDR_W:0]   i_count = '0;
    logic              i_ready = 1'b1;
    logic              o_busy;
    logic              o_done;
    logic              o_rom_en;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_last;
    logic [DATA_W-1:0] o_sum;

    always #5 i_clk = ~i_clk;

    rom_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_base     (i_base),
        .i_count    (i_count),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rom_en   (o_rom_en),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (rom_q),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_last     (o_last),
        .i_ready    (i_ready),
        .o_sum      (o_sum)
    );

    rom_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) rom (
        .i_clk  (i_clk),
        .i_en   (o_rom_en),
        .i_addr (o_rom_addr),
        .o_data (rom_q)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int         beats;
        logic [7:0] sum;
        int         zero_cyc;
    } sweep_t;

    beat_t  exp_beat_q[$];
    int     exp_addr_q[$];
    sweep_t exp_sweep_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int beats_total = 0;
    int beats_sweep = 0;
    int done_cnt = 0;
    int first_en_cyc = -1;
    int first_val_cyc = -1;
    int stall_req = 0;
    int rdy_mode = 0;
    logic       prev_stall = 1'b0;
    logic       last_xfer  = 1'b0;
    logic [7:0] held_data  = '0;
    logic       held_last  = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference ROM contents: ((a*37 + 11) mod 256) xor floor(a/8).
    function automatic logic [7:0] rom_model(input int a);
        return 8'(((a * 37 + 11) % 256) ^ (a / 8));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] got);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h, no such event expected (cycle %0d)", name, got, cyc);
    endtask

    task automatic start_sweep(input int base, input int cnt);
        int s;
        s = 0;
        @(posedge i_clk);
        #1;
        for (int i = 0; i < cnt; i++) begin
            int a;
            beat_t b;
            a = (base + i) % 256;
            b.data = rom_model(a);
            b.last = (i == cnt - 1);
            exp_addr_q.push_back(a);
            exp_beat_q.push_back(b);
            s = (s + int'(b.data)) % 256;
        end
        exp_sweep_q.push_back('{cnt, 8'(s), (cnt == 0) ? cyc + 1 : -1});
        first_en_cyc  = (cnt > 0) ? cyc + 1 : -1;
        first_val_cyc = (cnt > 0) ? cyc + 2 + int'(RD_LAT) : -1;
        i_base  = 8'(base);
        i_count = 9'(cnt);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge i_clk);
        if (done_cnt == d0) fail_now("done_timeout", 32'(budget));
    endtask

    // Downstream ready generator: tied high, random, held low, or a counted stall.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (stall_req > 0) begin
                i_ready = 1'b0;
                stall_req--;
            end else begin
                case (rdy_mode)
                    1:       i_ready = ($urandom_range(0, 3) != 0);
                    2:       i_ready = 1'b0;
                    default: i_ready = 1'b1;
                endcase
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an address, beat or done.
    always @(negedge i_clk) begin
        logic   xfer_last;
        beat_t  b;
        sweep_t sw;
        xfer_last = 1'b0;
        if (i_rst) begin
            prev_stall = 1'b0;
            last_xfer  = 1'b0;
        end else begin
            if (o_rom_en) begin
                chk("en_while_valid", 32'(o_valid), 32'd0);
                if (first_en_cyc >= 0) begin
                    chk("first_en_cycle", 32'(cyc), 32'(first_en_cyc));
                    first_en_cyc = -1;
                end
                if (exp_addr_q.size() == 0) fail_now("unexpected_rom_en", 32'(o_rom_addr));
                else chk("rom_addr", 32'(o_rom_addr), 32'(exp_addr_q.pop_front()));
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_data", 32'(o_data), 32'(held_data));
                chk("stall_last", 32'(o_last), 32'(held_last));
            end
            if (o_valid) begin
                chk("busy_while_valid", 32'(o_busy), 32'd1);
                if (first_val_cyc >= 0) begin
                    chk("first_valid_cycle", 32'(cyc), 32'(first_val_cyc));
                    first_val_cyc = -1;
                end
            end
            if (o_valid && i_ready) begin
                if (exp_beat_q.size() == 0) begin
                    fail_now("unexpected_beat", 32'(o_data));
                end else begin
                    b = exp_beat_q.pop_front();
                    chk("beat_data", 32'(o_data), 32'(b.data));
                    chk("beat_last", 32'(o_last), 32'(b.last));
                end
                beats_total++;
                beats_sweep++;
                xfer_last = o_last;
            end
            prev_stall = o_valid && !i_ready;
            held_data  = o_data;
            held_last  = o_last;
            if (o_done) begin
                done_cnt++;
                chk("busy_at_done", 32'(o_busy), 32'd0);
                if (exp_sweep_q.size() == 0) begin
                    fail_now("unexpected_done", 32'(o_sum));
                end else begin
                    sw = exp_sweep_q.pop_front();
                    chk("sweep_sum", 32'(o_sum), 32'(sw.sum));
                    chk("sweep_beats", 32'(beats_sweep), 32'(sw.beats));
                    if (sw.zero_cyc >= 0) chk("zero_done_cycle", 32'(cyc), 32'(sw.zero_cyc));
                    else chk("done_after_last", 32'(last_xfer), 32'd1);
                end
                beats_sweep = 0;
            end
            last_xfer = xfer_last;
        end
    end

    initial begin
        int b0;
        int base;
        int cnt;

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_rom_en", 32'(o_rom_en), 32'd0);
        chk("rst_rom_addr", 32'(o_rom_addr), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_sum", 32'(o_sum), 32'd0);

        // Plain sweep from address 0.
        rdy_mode = 0;
        start_sweep(0, 8);
        wait_done(100);

        // Empty sweep: immediate done, cleared sum.
        start_sweep(8'h33, 0);
        wait_done(10);

        // Address wrap at the top of the ROM.
        start_sweep(8'hFE, 4);
        wait_done(60);

        // Five-cycle downstream stall on the second beat.
        b0 = beats_total;
        start_sweep(0, 8);
        for (int i = 0; i < 50 && beats_total < b0 + 1; i++) @(negedge i_clk);
        if (beats_total < b0 + 1) fail_now("first_beat_timeout", 32'(beats_total));
        stall_req = 5;
        wait_done(150);

        // Start pulsed mid-sweep is ignored.
        start_sweep(10, 6);
        repeat (4) @(posedge i_clk);
        #1;
        i_base  = 8'h80;
        i_count = 9'd3;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_done(100);

        // Reset while a beat is held: sweep aborted with no done.
        b0 = beats_total;
        start_sweep(40, 8);
        for (int i = 0; i < 50 && beats_total < b0 + 2; i++) @(negedge i_clk);
        rdy_mode = 2;
        for (int i = 0; i < 20 && !(o_valid && !i_ready); i++) @(negedge i_clk);
        if (!(o_valid && !i_ready)) fail_now("hold_timeout", 32'(o_valid));
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        exp_beat_q.delete();
        exp_addr_q.delete();
        exp_sweep_q.delete();
        first_en_cyc  = -1;
        first_val_cyc = -1;
        beats_sweep   = 0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        rdy_mode = 0;
        @(negedge i_clk);
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_sum", 32'(o_sum), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_last", 32'(o_last), 32'd0);
        repeat (5) @(posedge i_clk);
        start_sweep(200, 5);
        wait_done(80);

        // Random sweeps with random backpressure, ending with a full-ROM sweep.
        rdy_mode = 1;
        for (int k = 0; k < 10; k++) begin
            base = int'($urandom_range(0, 255));
            cnt  = (k == 9) ? 256 : int'($urandom_range(1, 12));
            start_sweep(base, cnt);
            wait_done(cnt * 30 + 50);
        end
        rdy_mode = 0;

        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        chk("pending_beats", 32'(exp_beat_q.size()), 32'd0);
        chk("pending_addrs", 32'(exp_addr_q.size()), 32'd0);
        chk("pending_sweeps", 32'(exp_sweep_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
